// File: rtl/stream_demux_n.sv
// 1:NUM_CH valid/ready stream demux with per-channel output registers.
// Addressed or round-robin routing; bad addresses are dropped and counted.
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic                     drop_err,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  tgt;
  logic              sel_bad;
  logic [NSEL-1:0]   free_x;
  logic              acc;
  logic              drop;
  logic [NUM_CH-1:0] ld;

  assign tgt     = mode ? rr_ptr : in_sel;
  assign sel_bad = ~mode & ({1'b0, in_sel} >= NCH);

  // Padded to the full select range so tgt never indexes past the vector.
  always_comb begin
    free_x = '0;
    for (int k = 0; k < NUM_CH; k++)
      free_x[k] = ~out_valid[k] | out_ready[k];
  end

  assign in_ready = sel_bad | free_x[tgt];
  assign acc      = in_valid & in_ready & ~sel_bad;
  assign drop     = in_valid & sel_bad;

  always_comb begin
    ld = '0;
    for (int k = 0; k < NUM_CH; k++)
      ld[k] = acc & (tgt == SEL_W'(k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ld[k]) begin
          out_valid[k] <= 1'b1;
          out_data[k*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (acc && mode) begin
      rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_err <= drop;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: routing, stalls, round-robin,
// drop counting with saturation, and asynchronous reset.
module tb_stream_demux_n;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_mode, a_valid, a_ready;
  logic [7:0]  a_din;
  logic [1:0]  a_sel;
  logic [3:0]  a_ov, a_or;
  logic [31:0] a_dout;
  logic [1:0]  a_rr;
  logic        a_derr;
  logic [7:0]  a_dcnt;

  logic        b_mode, b_valid, b_ready;
  logic [7:0]  b_din;
  logic [1:0]  b_sel;
  logic [2:0]  b_ov, b_or;
  logic [23:0] b_dout;
  logic [1:0]  b_rr;
  logic        b_derr;
  logic [7:0]  b_dcnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_demux_n #(.DATA_W(8), .NUM_CH(4), .SEL_W(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode),
    .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_din), .in_sel(a_sel),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_dout),
    .rr_ptr(a_rr), .drop_err(a_derr), .drop_cnt(a_dcnt)
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(3), .SEL_W(2), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode),
    .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_din), .in_sel(b_sel),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_dout),
    .rr_ptr(b_rr), .drop_err(b_derr), .drop_cnt(b_dcnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] aslc(input int k);
    return a_dout[k*8 +: 8];
  endfunction

  initial begin
    rst_n   = 1'b0;
    a_mode  = 1'b0; a_valid = 1'b1; a_din = 8'hA5;
    a_sel   = 2'd2; a_or    = 4'b0000;
    b_mode  = 1'b0; b_valid = 1'b0; b_din = 8'h00;
    b_sel   = 2'd0; b_or    = 3'b111;

    // reset with in_valid held
    tick(); tick();
    check("rst_ov", 32'(a_ov), 32'h0);
    check("rst_od", a_dout, 32'h0);
    check("rst_rr", 32'(a_rr), 32'h0);
    check("rst_derr", 32'(a_derr), 32'h0);
    check("rst_dcnt", 32'(a_dcnt), 32'h0);

    // single addressed beat to ch2
    rst_n = 1'b1;
    tick();
    a_valid = 1'b0;
    #1;
    check("route_ov", 32'(a_ov), 32'h4);
    check("route_d2", 32'(aslc(2)), 32'hA5);

    // back-pressure isolation on ch1
    a_or = 4'b1101; a_valid = 1'b1;
    a_sel = 2'd1; a_din = 8'h11;
    #1 check("bp_rdy0", 32'(a_ready), 32'h1);
    tick();
    check("bp_ov0", 32'(a_ov), 32'h2);
    check("bp_d1a", 32'(aslc(1)), 32'h11);
    a_din = 8'h22;
    #1 check("bp_stall", 32'(a_ready), 32'h0);
    tick();
    check("bp_hold", 32'(aslc(1)), 32'h11);
    check("bp_ov1", 32'(a_ov), 32'h2);
    a_sel = 2'd3; a_din = 8'h33;
    #1 check("bp_rdy3", 32'(a_ready), 32'h1);
    tick();
    check("bp_ov2", 32'(a_ov), 32'hA);
    check("bp_d3", 32'(aslc(3)), 32'h33);
    check("bp_d1b", 32'(aslc(1)), 32'h11);
    a_or = 4'b1111; a_sel = 2'd1; a_din = 8'h22;
    #1 check("bp_pass", 32'(a_ready), 32'h1);
    tick();
    check("bp_ov3", 32'(a_ov), 32'h2);
    check("bp_d1c", 32'(aslc(1)), 32'h22);
    a_valid = 1'b0;
    tick();
    check("bp_idle", 32'(a_ov), 32'h0);
    check("bp_keep", 32'(aslc(1)), 32'h22);

    // full-rate pass-through to ch0
    a_valid = 1'b1; a_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      a_din = 8'h40 + 8'(i);
      #1 check("fr_rdy", 32'(a_ready), 32'h1);
      tick();
      check("fr_ov", 32'(a_ov), 32'h1);
      check("fr_d0", 32'(aslc(0)), 32'h40 + i);
    end
    a_valid = 1'b0;
    tick();
    check("fr_idle", 32'(a_ov), 32'h0);

    // round-robin wrap
    a_mode = 1'b1; a_sel = 2'd3; a_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_din = 8'(i + 1);
      #1 check("rr_ptr", 32'(a_rr), 32'(i % 4));
      tick();
      check("rr_ov", 32'(a_ov), 32'(1 << (i % 4)));
      check("rr_d", 32'(aslc(i % 4)), 32'(i + 1));
    end
    check("rr_end", 32'(a_rr), 32'h2);
    a_or = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      a_din = 8'h07 + 8'(i);
      tick();
    end
    a_din = 8'h0B;
    #1 check("rr_stall", 32'(a_ready), 32'h0);
    check("rr_ptr2", 32'(a_rr), 32'h2);
    tick();
    check("rr_hold", 32'(a_rr), 32'h2);
    check("rr_d2h", 32'(aslc(2)), 32'h07);
    a_or = 4'b1111;
    #1 check("rr_go", 32'(a_ready), 32'h1);
    tick();
    check("rr_d2n", 32'(aslc(2)), 32'h0B);
    check("rr_adv", 32'(a_rr), 32'h3);
    a_valid = 1'b0; a_mode = 1'b0;

    // drop on a 3-channel instance
    b_sel = 2'd3; b_valid = 1'b1;
    #1 check("dr_rdy", 32'(b_ready), 32'h1);
    tick();
    b_valid = 1'b0;
    #1;
    check("dr_ov", 32'(b_ov), 32'h0);
    check("dr_err1", 32'(b_derr), 32'h1);
    check("dr_cnt1", 32'(b_dcnt), 32'h1);
    tick();
    check("dr_err0", 32'(b_derr), 32'h0);
    b_sel = 2'd2; b_din = 8'h5C; b_valid = 1'b1;
    tick();
    check("dr_ok_ov", 32'(b_ov), 32'h4);
    check("dr_ok_d", 32'(b_dout[23:16]), 32'h5C);
    b_sel = 2'd3;
    for (int i = 0; i < 300; i++) tick();
    check("dr_sat", 32'(b_dcnt), 32'hFF);
    tick();
    check("dr_sat2", 32'(b_dcnt), 32'hFF);
    b_valid = 1'b0;

    // asynchronous reset mid-operation
    a_or = 4'b1110; a_sel = 2'd0; a_din = 8'h5A; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    check("ar_pre_ov", 32'(a_ov), 32'h1);
    check("ar_pre_rr", 32'(a_rr), 32'h3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("ar_ov", 32'(a_ov), 32'h0);
    check("ar_od", a_dout, 32'h0);
    check("ar_rr", 32'(a_rr), 32'h0);
    check("ar_bcnt", 32'(b_dcnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
